temp_zone_ctrl: RTL and testbench

- Multi-zone grain-store climate controller: N_ZONES independent heater/cooler channels, driven by temperature samples from the I2C sensor front end.
- Adds the following per zone:
  - persistence filtering of samples;
  - hysteresis on exit;
  - minimum actuator on-time;
  - a sticky critical alarm with acknowledge.
- Drives a single shared pulsed buzzer.
- Sits between the sensor readout block and the actuator/alarm GPIO drivers.

---
 rtl/temp_ctrl_pkg.sv | 28 ++
 rtl/temp_zone_fsm.sv | 128 ++++++++++++
 rtl/temp_zone_ctrl.sv | 79 +++++++
 tb/tb_temp_zone_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/temp_ctrl_pkg.sv
// Shared types and helpers for the grain-store zone climate controller.
// Counter widths are sized from the counter's maximum value.
package temp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } zone_state_t;

  localparam int unsigned DefPersist  = 3;
  localparam int unsigned DefMinOn    = 16;
  localparam int unsigned DefBeepHalf = 8;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned PersistW = cnt_w(DefPersist);
  localparam int unsigned DwellW   = cnt_w(DefMinOn);
  localparam int unsigned BeepW    = cnt_w(DefBeepHalf - 1);

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/temp_zone_fsm.sv
// One storage zone: sample persistence filters, HEAT/COOL FSM with hysteresis
// and minimum on-time, and a sticky critical alarm with acknowledge.
module temp_zone_fsm
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned TEMP_W  = 8,
  parameter int unsigned HYST    = 2,
  parameter int unsigned PERSIST = DefPersist,
  parameter int unsigned MIN_ON  = DefMinOn,
  parameter int unsigned CRIT    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] temp_low,
  input  logic [TEMP_W-1:0] temp_high,
  input  logic              sample_valid,
  input  logic              alarm_ack,
  output logic              heater_on,
  output logic              cooler_on,
  output logic              alarm
);

  localparam int unsigned PW = cnt_w(PERSIST);
  localparam int unsigned DW = cnt_w(MIN_ON);
  localparam int unsigned EW = TEMP_W + 1;

  typedef logic [EW-1:0] ext_t;

  localparam logic [PW-1:0] PersistMax = PW'(PERSIST);
  localparam logic [DW-1:0] DwellMax   = DW'(MIN_ON);

  // One extra bit so threshold +/- margin never wraps.
  ext_t t_ext, lo_ext, hi_ext;
  ext_t exit_low, exit_high, crit_low, crit_high;
  logic is_low, is_high, is_crit;

  assign t_ext     = {1'b0, temp};
  assign lo_ext    = {1'b0, temp_low};
  assign hi_ext    = {1'b0, temp_high};
  assign exit_low  = lo_ext + ext_t'(HYST);
  assign exit_high = ext_t'(sat_sub(32'(hi_ext), HYST));
  assign crit_low  = ext_t'(sat_sub(32'(lo_ext), CRIT));
  assign crit_high = hi_ext + ext_t'(CRIT);

  assign is_low  = t_ext < lo_ext;
  assign is_high = t_ext > hi_ext;
  assign is_crit = (t_ext < crit_low) || (t_ext > crit_high);

  zone_state_t   state_q, state_d;
  logic [PW-1:0] low_cnt_q, low_cnt_d;
  logic [PW-1:0] high_cnt_q, high_cnt_d;
  logic [PW-1:0] crit_cnt_q, crit_cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          heater_q, heater_d;
  logic          cooler_q, cooler_d;
  logic          alarm_q, alarm_d;

  always_comb begin
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    crit_cnt_d = crit_cnt_q;
    if (sample_valid) begin
      low_cnt_d  = !is_low  ? '0 : (low_cnt_q == PersistMax)  ? low_cnt_q  : low_cnt_q + 1'b1;
      high_cnt_d = !is_high ? '0 : (high_cnt_q == PersistMax) ? high_cnt_q : high_cnt_q + 1'b1;
      crit_cnt_d = !is_crit ? '0 : (crit_cnt_q == PersistMax) ? crit_cnt_q : crit_cnt_q + 1'b1;
    end

    state_d = state_q;
    dwell_d = (dwell_q == DwellMax) ? dwell_q : dwell_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (sample_valid && low_cnt_d == PersistMax) begin
          state_d = HEAT;
          dwell_d = '0;
        end else if (sample_valid && high_cnt_d == PersistMax) begin
          state_d = COOL;
          dwell_d = '0;
        end
      end
      HEAT: begin
        if (sample_valid && t_ext >= exit_low && dwell_q == DwellMax) state_d = IDLE;
      end
      COOL: begin
        if (sample_valid && t_ext <= exit_high && dwell_q == DwellMax) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    heater_d = (state_d == HEAT);
    cooler_d = (state_d == COOL);

    // Set has priority; ack only clears once the zone has left the critical band.
    alarm_d = alarm_q;
    if (crit_cnt_d == PersistMax) begin
      alarm_d = 1'b1;
    end else if (alarm_ack && crit_cnt_q == '0) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      crit_cnt_q <= '0;
      dwell_q    <= '0;
      heater_q   <= 1'b0;
      cooler_q   <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      crit_cnt_q <= crit_cnt_d;
      dwell_q    <= dwell_d;
      heater_q   <= heater_d;
      cooler_q   <= cooler_d;
      alarm_q    <= alarm_d;
    end
  end

  assign heater_on = heater_q;
  assign cooler_on = cooler_q;
  assign alarm     = alarm_q;

endmodule

// File: rtl/temp_zone_ctrl.sv
// Multi-zone climate controller top: per-zone FSM instances plus the shared
// pulsed buzzer that sounds while any zone alarm is latched.
module temp_zone_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned N_ZONES   = 4,
  parameter int unsigned TEMP_W    = 8,
  parameter int unsigned HYST      = 2,
  parameter int unsigned PERSIST   = DefPersist,
  parameter int unsigned MIN_ON    = DefMinOn,
  parameter int unsigned CRIT      = 10,
  parameter int unsigned BEEP_HALF = DefBeepHalf
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TEMP_W-1:0]         temp_low,
  input  logic [TEMP_W-1:0]         temp_high,
  input  logic                      sample_valid,
  input  logic [N_ZONES*TEMP_W-1:0] temps,
  input  logic [N_ZONES-1:0]        alarm_ack,
  output logic [N_ZONES-1:0]        heater_on,
  output logic [N_ZONES-1:0]        cooler_on,
  output logic [N_ZONES-1:0]        alarm,
  output logic                      buzzer
);

  localparam int unsigned BW = cnt_w(BEEP_HALF - 1);
  localparam logic [BW-1:0] BeepLast = BW'(BEEP_HALF - 1);

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    temp_zone_fsm #(
      .TEMP_W (TEMP_W),
      .HYST   (HYST),
      .PERSIST(PERSIST),
      .MIN_ON (MIN_ON),
      .CRIT   (CRIT)
    ) u_zone (
      .clk         (clk),
      .rst_n       (rst_n),
      .temp        (temps[z*TEMP_W +: TEMP_W]),
      .temp_low    (temp_low),
      .temp_high   (temp_high),
      .sample_valid(sample_valid),
      .alarm_ack   (alarm_ack[z]),
      .heater_on   (heater_on[z]),
      .cooler_on   (cooler_on[z]),
      .alarm       (alarm[z])
    );
  end

  logic          any_alarm;
  logic [BW-1:0] phase_q, phase_d;
  logic          buzzer_q, buzzer_d;

  assign any_alarm = |alarm;

  // Toggling on phase 0 makes the first high level land one cycle after the alarm.
  always_comb begin
    phase_d  = '0;
    buzzer_d = 1'b0;
    if (any_alarm) begin
      buzzer_d = (phase_q == '0) ? ~buzzer_q : buzzer_q;
      phase_d  = (phase_q == BeepLast) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      buzzer_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;

endmodule

// File: tb/tb_temp_zone_ctrl.sv
// Directed bench for temp_zone_ctrl: a vector table for the persistence filters
// plus hand sequences for dwell, alarm/buzzer, saturation and async reset.
module tb_temp_zone_ctrl;

  localparam int unsigned NZ = 4;
  localparam int unsigned TW = 8;
  localparam logic [7:0]  N  = 8'd25;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [TW-1:0]    temp_low, temp_high;
  logic             sample_valid;
  logic [NZ*TW-1:0] temps;
  logic [NZ-1:0]    alarm_ack;
  logic [NZ-1:0]    heater_on, cooler_on, alarm;
  logic             buzzer;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  temp_zone_ctrl #(
    .N_ZONES  (NZ),
    .TEMP_W   (TW),
    .HYST     (2),
    .PERSIST  (3),
    .MIN_ON   (16),
    .CRIT     (10),
    .BEEP_HALF(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .temp_low    (temp_low),
    .temp_high   (temp_high),
    .sample_valid(sample_valid),
    .temps       (temps),
    .alarm_ack   (alarm_ack),
    .heater_on   (heater_on),
    .cooler_on   (cooler_on),
    .alarm       (alarm),
    .buzzer      (buzzer)
  );

  typedef struct {
    logic             sv;
    logic [NZ*TW-1:0] t;
    logic [NZ-1:0]    ack;
    logic [NZ-1:0]    exp_heat;
    logic [NZ-1:0]    exp_cool;
    logic [NZ-1:0]    exp_alarm;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [NZ*TW-1:0] pk(input logic [7:0] z0, input logic [7:0] z1,
                                          input logic [7:0] z2, input logic [7:0] z3);
    return {z3, z2, z1, z0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, sample 1ns after the edge.
  task automatic step(input logic sv, input logic [NZ*TW-1:0] t, input logic [NZ-1:0] ack);
    sample_valid = sv;
    temps        = t;
    alarm_ack    = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    temps        = pk(N, N, N, N);
    alarm_ack    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    temp_low  = 8'd20;
    temp_high = 8'd30;

    // Persistence filtering, thresholds 20/30.
    vecs[0]  = '{1'b0, pk(N,  N,  N, N), 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, pk(18, N,  N, N), 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, pk(18, N,  N, N), 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[3]  = '{1'b1, pk(18, N,  N, N), 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[4]  = '{1'b1, pk(18, N,  N, N), 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[5]  = '{1'b1, pk(18, 31, N, N), 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[6]  = '{1'b1, pk(18, 31, N, N), 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[7]  = '{1'b1, pk(18, 25, N, N), 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[8]  = '{1'b1, pk(18, 31, N, N), 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[9]  = '{1'b1, pk(18, 31, N, N), 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[10] = '{1'b1, pk(18, 31, N, N), 4'h0, 4'h1, 4'h2, 4'h0};

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    temps        = pk(N, N, N, N);
    alarm_ack    = '0;
    #2;
    check("reset heater", 32'(heater_on), 32'h0);
    check("reset buzzer", 32'(buzzer), 32'h0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].sv, vecs[i].t, vecs[i].ack);
      check($sformatf("vec%0d heater", i), 32'(heater_on), 32'(vecs[i].exp_heat));
      check($sformatf("vec%0d cooler", i), 32'(cooler_on), 32'(vecs[i].exp_cool));
      check($sformatf("vec%0d alarm", i), 32'(alarm), 32'(vecs[i].exp_alarm));
    end

    // Minimum on-time: strobes every 2 cycles; 21 never exits, 22 exits only at dwell 16.
    do_reset();
    repeat (3) step(1'b1, pk(18, N, N, N), 4'h0);
    check("dwell entry heater", 32'(heater_on), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      step((k % 2) == 0, pk((k == 18) ? 8'd21 : 8'd22, N, N, N), 4'h0);
      check($sformatf("dwell k=%0d heater", k), 32'(heater_on), (k < 20) ? 32'h1 : 32'h0);
    end

    // Critical alarm on zone 2 and buzzer cadence.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pk(N, N, 45, N), 4'h0);
      check($sformatf("crit strobe%0d alarm", i), 32'(alarm), (i == 2) ? 32'h4 : 32'h0);
    end
    check("buzzer at alarm edge", 32'(buzzer), 32'h0);
    for (int n = 1; n <= 17; n++) begin
      step(1'b0, pk(N, N, 45, N), 4'h0);
      check($sformatf("buzzer n=%0d", n), 32'(buzzer), (((n - 1) / 8) % 2 == 0) ? 32'h1 : 32'h0);
    end
    step(1'b0, pk(N, N, 45, N), 4'h4);
    check("ack while critical", 32'(alarm), 32'h4);
    step(1'b1, pk(N, N, 45, N), 4'h4);
    check("ack with critical strobe", 32'(alarm), 32'h4);
    step(1'b1, pk(N, N, 28, N), 4'h0);
    check("clear strobe no ack", 32'(alarm), 32'h4);
    step(1'b0, pk(N, N, 28, N), 4'h4);
    check("ack after clear", 32'(alarm), 32'h0);
    step(1'b0, pk(N, N, 28, N), 4'h0);
    check("buzzer off", 32'(buzzer), 32'h0);

    // Saturating critical bounds: crit_low clamps at 0, crit_high exceeds 255.
    do_reset();
    temp_low  = 8'd5;
    temp_high = 8'd250;
    repeat (3) step(1'b1, pk(N, 8'd255, N, 8'd0), 4'h0);
    check("sat heater", 32'(heater_on), 32'h8);
    check("sat cooler", 32'(cooler_on), 32'h2);
    check("sat alarm", 32'(alarm), 32'h0);
    repeat (3) step(1'b1, pk(N, 8'd255, N, 8'd0), 4'h0);
    check("sat alarm later", 32'(alarm), 32'h0);

    // Asynchronous reset mid-operation, then full re-qualification.
    do_reset();
    temp_low  = 8'd20;
    temp_high = 8'd30;
    repeat (3) step(1'b1, pk(18, N, 45, N), 4'h0);
    check("pre-reset heater", 32'(heater_on), 32'h1);
    check("pre-reset alarm", 32'(alarm), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async heater", 32'(heater_on), 32'h0);
    check("async cooler", 32'(cooler_on), 32'h0);
    check("async alarm", 32'(alarm), 32'h0);
    check("async buzzer", 32'(buzzer), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pk(18, N, N, N), 4'h0);
      check($sformatf("requal%0d heater", i), 32'(heater_on), (i == 2) ? 32'h1 : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
